// File: rtl/rggen_bit_field_counter.sv
// Counter register bit field: hardware up/down counting with wrap or saturate,
// sticky overflow/underflow flags, a threshold-crossing pulse and SW write-load/read-clear.
module rggen_bit_field_counter #(
  parameter int               WIDTH                    = 16,
  parameter logic [WIDTH-1:0] INITIAL_VALUE            = {WIDTH{1'b0}},
  parameter int               STEP_WIDTH               = 1,
  parameter bit               SATURATE                 = 1'b0,
  parameter bit               SW_READ_CLEAR            = 1'b0,
  parameter bit               SW_WRITE_ENABLE_POLARITY = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sw_valid,
  input  logic [WIDTH-1:0]      i_sw_read_mask,
  input  logic                  i_sw_write_enable,
  input  logic [WIDTH-1:0]      i_sw_write_mask,
  input  logic [WIDTH-1:0]      i_sw_write_data,
  output logic [WIDTH-1:0]      o_sw_read_data,
  output logic [WIDTH-1:0]      o_sw_value,
  input  logic                  i_hw_clear,
  input  logic                  i_hw_up,
  input  logic                  i_hw_down,
  input  logic [STEP_WIDTH-1:0] i_hw_step,
  input  logic [WIDTH-1:0]      i_threshold,
  input  logic [WIDTH-1:0]      i_mask,
  output logic [WIDTH-1:0]      o_value,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_threshold_hit
);

  logic [WIDTH-1:0]        value;
  logic [WIDTH-1:0]        base;
  logic [WIDTH-1:0]        next_value;
  logic                    overflow;
  logic                    underflow;
  logic                    threshold_hit;
  logic                    sw_write;
  logic                    sw_rclr;
  logic                    overflow_event;
  logic                    underflow_event;
  logic                    hit_event;
  logic signed [WIDTH+1:0] step_ext;
  logic signed [WIDTH+1:0] delta;
  logic signed [WIDTH+1:0] sum;

  always_comb begin
    sw_write = i_sw_valid && (i_sw_write_mask != '0) &&
               (i_sw_write_enable == SW_WRITE_ENABLE_POLARITY);
    sw_rclr  = SW_READ_CLEAR && i_sw_valid && (i_sw_read_mask != '0) && !sw_write;

    // The count is applied on top of the SW-updated value so no event is lost.
    if (sw_write) begin
      base = (value & ~i_sw_write_mask) | (i_sw_write_data & i_sw_write_mask);
    end else if (sw_rclr) begin
      base = '0;
    end else begin
      base = value;
    end

    step_ext = signed'({{(WIDTH+2-STEP_WIDTH){1'b0}}, i_hw_step});
    if (i_hw_up && !i_hw_down) begin
      delta = step_ext;
    end else if (i_hw_down && !i_hw_up) begin
      delta = -step_ext;
    end else begin
      delta = '0;
    end

    sum             = signed'({2'b00, base}) + delta;
    underflow_event = sum[WIDTH+1];
    overflow_event  = !sum[WIDTH+1] && sum[WIDTH];

    if (SATURATE && overflow_event) begin
      next_value = '1;
    end else if (SATURATE && underflow_event) begin
      next_value = '0;
    end else begin
      next_value = sum[WIDTH-1:0];
    end

    hit_event = (delta != '0) && !sw_write &&
                (value < i_threshold) && (next_value >= i_threshold);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value         <= INITIAL_VALUE;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      threshold_hit <= 1'b0;
    end else if (i_hw_clear) begin
      value         <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      threshold_hit <= 1'b0;
    end else begin
      value         <= next_value;
      // A same-cycle event wins over the SW clear of the sticky flags.
      overflow      <= overflow_event  || (overflow  && !(sw_write || sw_rclr));
      underflow     <= underflow_event || (underflow && !(sw_write || sw_rclr));
      threshold_hit <= hit_event;
    end
  end

  assign o_sw_read_data  = value & i_mask;
  assign o_sw_value      = value;
  assign o_value         = value & i_mask;
  assign o_overflow      = overflow;
  assign o_underflow     = underflow;
  assign o_threshold_hit = threshold_hit;

endmodule

// File: tb/tb_rggen_bit_field_counter.sv
// Bench for rggen_bit_field_counter: a wrapping/read-clear instance and a saturating
// instance share stimulus; a behavioural model queues expected state per clock.
module tb_rggen_bit_field_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_valid, sw_write_enable, hw_clear, hw_up, hw_down;
  logic [7:0] sw_read_mask, sw_write_mask, sw_write_data, threshold, mask;
  logic [3:0] hw_step;

  logic [7:0] a_read_data, a_sw_value, a_value, b_read_data, b_sw_value, b_value;
  logic       a_ov, a_un, a_hit, b_ov, b_un, b_hit;

  int total = 0;
  int bad = 0;

  // Per-instance model configuration: index 0 = dut_a, 1 = dut_b
  bit         cfg_sat [2] = '{1'b0, 1'b1};
  bit         cfg_rc  [2] = '{1'b1, 1'b0};
  int         cfg_init[2] = '{8'h5A, 8'h03};
  int         m_val[2];
  bit         m_ov[2], m_un[2], m_hit[2];
  logic [21:0] sb[$];
  logic [21:0] exp_v;
  logic [21:0] junk;

  always #5 clk = ~clk;

  rggen_bit_field_counter #(
    .WIDTH(8), .INITIAL_VALUE(8'h5A), .STEP_WIDTH(4),
    .SATURATE(1'b0), .SW_READ_CLEAR(1'b1), .SW_WRITE_ENABLE_POLARITY(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_valid(sw_valid), .i_sw_read_mask(sw_read_mask),
    .i_sw_write_enable(sw_write_enable), .i_sw_write_mask(sw_write_mask),
    .i_sw_write_data(sw_write_data), .o_sw_read_data(a_read_data), .o_sw_value(a_sw_value),
    .i_hw_clear(hw_clear), .i_hw_up(hw_up), .i_hw_down(hw_down), .i_hw_step(hw_step),
    .i_threshold(threshold), .i_mask(mask), .o_value(a_value), .o_overflow(a_ov),
    .o_underflow(a_un), .o_threshold_hit(a_hit)
  );

  rggen_bit_field_counter #(
    .WIDTH(8), .INITIAL_VALUE(8'h03), .STEP_WIDTH(4),
    .SATURATE(1'b1), .SW_READ_CLEAR(1'b0), .SW_WRITE_ENABLE_POLARITY(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_valid(sw_valid), .i_sw_read_mask(sw_read_mask),
    .i_sw_write_enable(sw_write_enable), .i_sw_write_mask(sw_write_mask),
    .i_sw_write_data(sw_write_data), .o_sw_read_data(b_read_data), .o_sw_value(b_sw_value),
    .i_hw_clear(hw_clear), .i_hw_up(hw_up), .i_hw_down(hw_down), .i_hw_step(hw_step),
    .i_threshold(threshold), .i_mask(mask), .o_value(b_value), .o_overflow(b_ov),
    .o_underflow(b_un), .o_threshold_hit(b_hit)
  );

  function automatic logic [21:0] observed();
    return {a_sw_value, a_ov, a_un, a_hit, b_sw_value, b_ov, b_un, b_hit};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = cfg_init[i];
      m_ov[i] = 1'b0; m_un[i] = 1'b0; m_hit[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_cycle();
    for (int i = 0; i < 2; i++) begin
      int v, base, delta, sum, nv;
      bit wr, rclr, ov_e, un_e;
      v     = m_val[i];
      wr    = sw_valid && (sw_write_mask != 8'h00) && (sw_write_enable == 1'b1);
      rclr  = cfg_rc[i] && sw_valid && (sw_read_mask != 8'h00) && !wr;
      base  = wr ? (((v & ~int'(sw_write_mask)) | (int'(sw_write_data) & int'(sw_write_mask))) & 255)
                 : (rclr ? 0 : v);
      delta = (hw_up && !hw_down) ? int'(hw_step) : ((hw_down && !hw_up) ? -int'(hw_step) : 0);
      sum   = base + delta;
      ov_e  = sum > 255;
      un_e  = sum < 0;
      nv    = (cfg_sat[i] && ov_e) ? 255 : ((cfg_sat[i] && un_e) ? 0 : (sum & 255));
      if (hw_clear) begin
        m_val[i] = 0; m_ov[i] = 1'b0; m_un[i] = 1'b0; m_hit[i] = 1'b0;
      end else begin
        m_hit[i] = (delta != 0) && !wr && (v < int'(threshold)) && (nv >= int'(threshold));
        m_ov[i]  = ov_e || (m_ov[i] && !(wr || rclr));
        m_un[i]  = un_e || (m_un[i] && !(wr || rclr));
        m_val[i] = nv;
      end
    end
    sb.push_back({m_val[0][7:0], m_ov[0], m_un[0], m_hit[0],
                  m_val[1][7:0], m_ov[1], m_un[1], m_hit[1]});
  endtask

  task automatic cycle();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sw_valid = 1'b0; sw_read_mask = 8'h00; sw_write_enable = 1'b0;
    sw_write_mask = 8'h00; sw_write_data = 8'h00;
    hw_clear = 1'b0; hw_up = 1'b0; hw_down = 1'b0; hw_step = 4'd0;
  endtask

  task automatic count(input logic up, input logic down, input logic [3:0] step);
    idle();
    hw_up = up; hw_down = down; hw_step = step;
  endtask

  task automatic sw_load(input logic [7:0] v);
    idle();
    sw_valid = 1'b1; sw_write_enable = 1'b1; sw_write_mask = 8'hFF; sw_write_data = v;
    cycle();
    junk = sb.pop_front();
    idle();
  endtask

  task automatic test_reset();
    idle(); threshold = 8'h00; mask = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_sw_value, a_ov, a_un, a_hit} !== {8'h5A, 3'b000}) begin
      bad++; $display("[TB] FAIL reset_a: got %h want %h", {a_sw_value, a_ov, a_un, a_hit}, {8'h5A, 3'b000});
    end
    total++;
    if ({b_sw_value, b_ov, b_un, b_hit} !== {8'h03, 3'b000}) begin
      bad++; $display("[TB] FAIL reset_b: got %h want %h", {b_sw_value, b_ov, b_un, b_hit}, {8'h03, 3'b000});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    sw_load(8'hFE);
    count(1'b1, 1'b0, 4'd3);
    cycle();
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v) begin
      bad++; $display("[TB] FAIL wrap_step: got %h want %h", observed(), exp_v);
    end
    total++;
    if ({a_sw_value, a_ov, b_sw_value, b_ov} !== {8'h01, 1'b1, 8'hFF, 1'b1}) begin
      bad++; $display("[TB] FAIL wrap_const: got %h want %h", {a_sw_value, a_ov, b_sw_value, b_ov}, {8'h01, 1'b1, 8'hFF, 1'b1});
    end
    idle();
    repeat (2) begin
      cycle();
      exp_v = sb.pop_front();
      total++;
      if (observed() !== exp_v || a_ov !== 1'b1) begin
        bad++; $display("[TB] FAIL wrap_sticky: got %h want %h", observed(), exp_v);
      end
    end
    sw_load(8'h01);
    total++;
    if ({a_ov, b_ov} !== 2'b00) begin
      bad++; $display("[TB] FAIL wrap_flag_clear: got %b want 00", {a_ov, b_ov});
    end
  endtask

  task automatic test_saturate();
    sw_load(8'h02);
    count(1'b0, 1'b1, 4'd5);
    for (int k = 0; k < 2; k++) begin
      cycle();
      exp_v = sb.pop_front();
      total++;
      if (observed() !== exp_v) begin
        bad++; $display("[TB] FAIL sat_step%0d: got %h want %h", k, observed(), exp_v);
      end
      total++;
      if ({b_sw_value, b_un} !== {8'h00, 1'b1}) begin
        bad++; $display("[TB] FAIL sat_const%0d: got %h want %h", k, {b_sw_value, b_un}, {8'h00, 1'b1});
      end
    end
    total++;
    if (a_sw_value !== 8'hF8) begin
      bad++; $display("[TB] FAIL wrap_down: got %h want f8", a_sw_value);
    end
  endtask

  task automatic test_read_clear();
    sw_load(8'h10);
    count(1'b1, 1'b0, 4'd1);
    sw_valid = 1'b1; sw_read_mask = 8'hFF;
    #1;
    total++;
    if (a_read_data !== 8'h10) begin
      bad++; $display("[TB] FAIL rclr_read_data: got %h want 10", a_read_data);
    end
    cycle();
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v || a_sw_value !== 8'h01 || b_sw_value !== 8'h11) begin
      bad++; $display("[TB] FAIL rclr_next: got %h want %h", observed(), exp_v);
    end
  endtask

  task automatic test_write_load();
    sw_load(8'hFF);
    count(1'b1, 1'b0, 4'd1);
    cycle();
    junk = sb.pop_front();
    threshold = 8'h41;
    count(1'b1, 1'b0, 4'd2);
    sw_valid = 1'b1; sw_write_enable = 1'b1; sw_write_mask = 8'hFF; sw_write_data = 8'h40;
    cycle();
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v) begin
      bad++; $display("[TB] FAIL wload_model: got %h want %h", observed(), exp_v);
    end
    total++;
    if (observed() !== {8'h42, 3'b000, 8'h42, 3'b000}) begin
      bad++; $display("[TB] FAIL wload_const: got %h want %h", observed(), {8'h42, 3'b000, 8'h42, 3'b000});
    end
    threshold = 8'h00;
    idle();
  endtask

  task automatic test_threshold();
    logic [2:0] ups   [6] = '{1, 0, 1, 0, 1, 0};
    logic [2:0] steps [6] = '{1, 0, 1, 2, 1, 0};
    logic       hits  [6] = '{1, 0, 0, 0, 1, 0};
    sw_load(8'h04);
    threshold = 8'h05;
    for (int k = 0; k < 6; k++) begin
      if (steps[k] == 3'd0) count(1'b0, 1'b0, 4'd0);
      else if (ups[k] != 3'd0) count(1'b1, 1'b0, 4'(steps[k]));
      else count(1'b0, 1'b1, 4'(steps[k]));
      cycle();
      exp_v = sb.pop_front();
      total++;
      if (observed() !== exp_v || a_hit !== hits[k] || b_hit !== hits[k]) begin
        bad++; $display("[TB] FAIL thresh_step%0d: got %h hit %b want %h hit %b", k, observed(), a_hit, exp_v, hits[k]);
      end
    end
    threshold = 8'h00;
    mask = 8'h0F;
    #1;
    total++;
    if (a_value !== (a_sw_value & 8'h0F) || a_read_data !== (a_sw_value & 8'h0F) || a_sw_value !== 8'h05) begin
      bad++; $display("[TB] FAIL mask_out: got %h/%h want %h", a_value, a_read_data, 8'h05);
    end
    mask = 8'hFF;
  endtask

  task automatic test_clear();
    sw_load(8'h20);
    count(1'b1, 1'b1, 4'd3);
    cycle();
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v || a_sw_value !== 8'h20) begin
      bad++; $display("[TB] FAIL up_down: got %h want %h", observed(), exp_v);
    end
    sw_load(8'hFF);
    count(1'b1, 1'b0, 4'd1);
    cycle();
    junk = sb.pop_front();
    count(1'b1, 1'b0, 4'd4);
    hw_clear = 1'b1;
    cycle();
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v || observed() !== 22'd0) begin
      bad++; $display("[TB] FAIL hw_clear: got %h want %h", observed(), exp_v);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      idle();
      hw_up = 1'($urandom_range(0, 1));
      hw_down = 1'($urandom_range(0, 1));
      hw_step = 4'($urandom_range(0, 15));
      threshold = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        sw_valid = 1'b1; sw_write_enable = 1'b1;
        sw_write_mask = 8'($urandom_range(0, 255)); sw_write_data = 8'($urandom_range(0, 255));
      end else if ($urandom_range(0, 5) == 0) begin
        sw_valid = 1'b1; sw_read_mask = 8'hFF;
      end
      hw_clear = ($urandom_range(0, 15) == 0);
      cycle();
      exp_v = sb.pop_front();
      total++;
      if (observed() !== exp_v) begin
        bad++; $display("[TB] FAIL b2b_%0d: got %h want %h", k, observed(), exp_v);
      end
    end
    threshold = 8'h00;
    idle();
  endtask

  task automatic test_reset_mid();
    sw_load(8'h30);
    count(1'b1, 1'b0, 4'd2);
    cycle();
    junk = sb.pop_front();
    #3;
    rst_n = 1'b0;
    idle();
    #1;
    total++;
    if ({a_sw_value, a_ov, a_un, a_hit, b_sw_value, b_ov, b_un, b_hit} !== {8'h5A, 3'b000, 8'h03, 3'b000}) begin
      bad++; $display("[TB] FAIL reset_mid: got %h want %h", observed(), {8'h5A, 3'b000, 8'h03, 3'b000});
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    count(1'b1, 1'b0, 4'd1);
    cycle();
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v) begin
      bad++; $display("[TB] FAIL after_reset: got %h want %h", observed(), exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_read_clear();
    test_write_load();
    test_threshold();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
